// File: rtl/pht_pkg.sv
// Shared definitions for the pattern-history table: counter width, counter
// encodings and the write-controller state type.
package pht_pkg;

  localparam int PHT_CNT_W = 2;

  localparam logic [PHT_CNT_W-1:0] SNT = 2'b00;
  localparam logic [PHT_CNT_W-1:0] WNT = 2'b01;
  localparam logic [PHT_CNT_W-1:0] WT  = 2'b10;
  localparam logic [PHT_CNT_W-1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pht_state_e;

endpackage

// File: rtl/sat_cnt2_next.sv
// Next-state function of a 2-bit saturating branch counter. Shared with the
// front-end speculative-history logic, so it stays purely combinational.
module sat_cnt2_next
  import pht_pkg::*;
(
  input  logic [PHT_CNT_W-1:0] cnt,
  input  logic                 taken,
  output logic [PHT_CNT_W-1:0] next
);

  // Saturate at ST when taken and at SNT when not taken; never wrap.
  always_comb begin
    next = cnt;
    if (taken) begin
      if (cnt != ST) next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/pht_cnt_writer.sv
// Write-side controller for the PHT LUTRAM: sweeps every entry to INIT_VAL
// after reset or clear, then applies branch updates as a 2-stage read-modify-write.
module pht_cnt_writer
  import pht_pkg::*;
#(
  parameter int                   AW       = 5,
  parameter logic [PHT_CNT_W-1:0] INIT_VAL = WNT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 upd_valid_i,
  output logic                 upd_ready_o,
  input  logic [AW-1:0]        upd_idx_i,
  input  logic                 upd_taken_i,
  output logic [AW-1:0]        ram_ra_o,
  input  logic [PHT_CNT_W-1:0] ram_rd_i,
  output logic                 ram_we_o,
  output logic [AW-1:0]        ram_wa_o,
  output logic [PHT_CNT_W-1:0] ram_wd_o,
  output logic                 init_busy_o
);

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  pht_state_e           state;
  logic [AW-1:0]        sweep_cnt;
  logic                 s1_v;
  logic [AW-1:0]        s1_idx;
  logic                 s1_taken;
  logic                 s2_v;
  logic                 accept;
  logic                 bypass;
  logic [PHT_CNT_W-1:0] cnt;
  logic [PHT_CNT_W-1:0] cnt_next;

  assign upd_ready_o = (state == RUN) && !clear_i;
  assign accept      = upd_valid_i && upd_ready_o;
  assign init_busy_o = (state != RUN);
  assign ram_ra_o    = s1_idx;

  // The registered write port doubles as the S2 idx/data; its write lands one
  // edge after S1 reads, so a same-index S1 must take the S2 value instead.
  assign bypass = s2_v && (ram_wa_o == s1_idx);
  assign cnt    = bypass ? ram_wd_o : ram_rd_i;

  sat_cnt2_next u_next (
    .cnt   (cnt),
    .taken (s1_taken),
    .next  (cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      s1_v      <= 1'b0;
      s1_idx    <= '0;
      s1_taken  <= 1'b0;
      s2_v      <= 1'b0;
      ram_we_o  <= 1'b1;
      ram_wa_o  <= '0;
      ram_wd_o  <= INIT_VAL;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_idx   <= upd_idx_i;
        s1_taken <= upd_taken_i;
      end

      case (state)
        SWEEP: begin
          if (sweep_cnt == LAST_IDX) begin
            state    <= RUN;
            ram_we_o <= 1'b0;
            s2_v     <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + AW'(1);
            ram_we_o  <= 1'b1;
            ram_wa_o  <= sweep_cnt + AW'(1);
            ram_wd_o  <= INIT_VAL;
          end
        end

        RUN, DRAIN: begin
          s2_v     <= s1_v;
          ram_we_o <= s1_v;
          if (s1_v) begin
            ram_wa_o <= s1_idx;
            ram_wd_o <= cnt_next;
          end
          // Leaving DRAIN only once both stages are empty lets in-flight
          // updates commit before the sweep overwrites them.
          if (state == RUN && clear_i) begin
            state <= DRAIN;
          end else if (state == DRAIN && !s1_v && !s2_v) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            ram_we_o  <= 1'b1;
            ram_wa_o  <= '0;
            ram_wd_o  <= INIT_VAL;
          end
        end

        default: state <= SWEEP;
      endcase
    end
  end

endmodule

// File: tb/tb_pht_cnt_writer.sv
// Bench for pht_cnt_writer: behavioural 32x2 RAM, a write-port scoreboard and
// a table of back-to-back update vectors plus reset/clear corner sequences.
module tb_pht_cnt_writer;
  import pht_pkg::*;

  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear_i = 1'b0;
  logic          upd_valid_i = 1'b0;
  logic          upd_ready_o;
  logic [AW-1:0] upd_idx_i = '0;
  logic          upd_taken_i = 1'b0;
  logic [AW-1:0] ram_ra_o;
  logic [1:0]    ram_rd_i;
  logic          ram_we_o;
  logic [AW-1:0] ram_wa_o;
  logic [1:0]    ram_wd_o;
  logic          init_busy_o;

  logic [1:0] ram   [N];
  logic [1:0] model [N];

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [1:0]    wd;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [AW-1:0] idx;
    logic          taken;
    logic [1:0]    exp;
    int            gap;
  } vec_t;
  vec_t vec[20];

  int nChecks = 0;
  int nFails  = 0;
  bit monOn   = 1'b0;

  always #5 clk = ~clk;

  assign ram_rd_i = ram[ram_ra_o];
  always @(posedge clk) if (ram_we_o) ram[ram_wa_o] <= ram_wd_o;

  pht_cnt_writer #(.AW(AW), .INIT_VAL(2'b01)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .upd_valid_i (upd_valid_i),
    .upd_ready_o (upd_ready_o),
    .upd_idx_i   (upd_idx_i),
    .upd_taken_i (upd_taken_i),
    .ram_ra_o    (ram_ra_o),
    .ram_rd_i    (ram_rd_i),
    .ram_we_o    (ram_we_o),
    .ram_wa_o    (ram_wa_o),
    .ram_wd_o    (ram_wd_o),
    .init_busy_o (init_busy_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] satNext(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  task automatic pushSweep();
    for (int i = 0; i < N; i++) begin
      sb.push_back('{wa: AW'(i), wd: 2'b01});
      model[i] = 2'b01;
    end
  endtask

  // Write-port monitor: every write seen must match the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (monOn && rst_n && ram_we_o) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_write: got wa=%0d wd=%0d, expected no write", ram_wa_o, ram_wd_o);
      end else begin
        e = sb.pop_front();
        checkOutput("write_addr", 32'(ram_wa_o), 32'(e.wa));
        checkOutput("write_data", 32'(ram_wd_o), 32'(e.wd));
      end
    end
  end

  // Called at posedge+1; holds reset across one edge and releases at posedge+1.
  task automatic resetDut();
    rst_n       = 1'b0;
    upd_valid_i = 1'b0;
    clear_i     = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(upd_ready_o), 32'd0);
    checkOutput("rst_busy",  32'(init_busy_o), 32'd1);
    checkOutput("rst_we",    32'(ram_we_o),    32'd1);
    checkOutput("rst_wa",    32'(ram_wa_o),    32'd0);
    checkOutput("rst_wd",    32'(ram_wd_o),    32'd1);
    checkOutput("rst_ra",    32'(ram_ra_o),    32'd0);
    sb.delete();
    pushSweep();
    monOn = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitSweep(input string name);
    int k = 0;
    while (init_busy_o && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput({name, "_busy_low"}, 32'(init_busy_o), 32'd0);
    checkOutput({name, "_ready"},    32'(upd_ready_o), 32'd1);
    checkOutput({name, "_sb_empty"}, 32'(sb.size()),   32'd0);
  endtask

  task automatic applyStimulus(input logic [AW-1:0] idx, input logic taken, input logic [1:0] exp);
    upd_valid_i = 1'b1;
    upd_idx_i   = idx;
    upd_taken_i = taken;
    checkOutput("upd_ready", 32'(upd_ready_o), 32'd1);
    if (upd_ready_o) begin
      sb.push_back('{wa: idx, wd: exp});
      model[idx] = exp;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;

    vec[0]  = '{5'd7,  1'b1, 2'd2, 0};
    vec[1]  = '{5'd7,  1'b1, 2'd3, 0};
    vec[2]  = '{5'd7,  1'b1, 2'd3, 0};
    vec[3]  = '{5'd7,  1'b1, 2'd3, 3};
    vec[4]  = '{5'd7,  1'b0, 2'd2, 0};
    vec[5]  = '{5'd7,  1'b0, 2'd1, 0};
    vec[6]  = '{5'd7,  1'b0, 2'd0, 0};
    vec[7]  = '{5'd7,  1'b0, 2'd0, 3};
    vec[8]  = '{5'd9,  1'b1, 2'd2, 0};
    vec[9]  = '{5'd9,  1'b1, 2'd3, 0};
    vec[10] = '{5'd9,  1'b1, 2'd3, 3};
    vec[11] = '{5'd9,  1'b0, 2'd2, 0};
    vec[12] = '{5'd9,  1'b0, 2'd1, 3};
    vec[13] = '{5'd9,  1'b1, 2'd2, 0};
    vec[14] = '{5'd9,  1'b0, 2'd1, 0};
    vec[15] = '{5'd9,  1'b1, 2'd2, 3};
    vec[16] = '{5'd10, 1'b1, 2'd2, 0};
    vec[17] = '{5'd11, 1'b0, 2'd0, 0};
    vec[18] = '{5'd10, 1'b1, 2'd3, 0};
    vec[19] = '{5'd10, 1'b0, 2'd2, 3};

    @(posedge clk);
    #1;
    resetDut();

    // Power-up sweep: busy through edge 31, running after edge 32.
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      if (i == 31) checkOutput("busy_before_32", 32'(init_busy_o), 32'd1);
    end
    checkOutput("busy_at_32",  32'(init_busy_o), 32'd0);
    checkOutput("ready_at_32", 32'(upd_ready_o), 32'd1);
    checkOutput("sweep_seen",  32'(sb.size()),   32'd0);

    // Single update latency.
    applyStimulus(5'd5, 1'b1, 2'd2);
    upd_valid_i = 1'b0;
    checkOutput("t_we",   32'(ram_we_o), 32'd0);
    checkOutput("t_ra",   32'(ram_ra_o), 32'd5);
    @(posedge clk);
    #1;
    checkOutput("t1_we",  32'(ram_we_o), 32'd1);
    checkOutput("t1_wa",  32'(ram_wa_o), 32'd5);
    checkOutput("t1_wd",  32'(ram_wd_o), 32'd2);
    checkOutput("t1_ram", 32'(ram[5]),   32'd1);
    @(posedge clk);
    #1;
    checkOutput("t2_ram", 32'(ram[5]),   32'd2);
    checkOutput("t2_we",  32'(ram_we_o), 32'd0);

    // Saturation and bypass vectors.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vec[i].idx, vec[i].taken, vec[i].exp);
      if (vec[i].gap > 0) begin
        upd_valid_i = 1'b0;
        repeat (vec[i].gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    checkOutput("ram7_sat_low", 32'(ram[7]),  32'd0);
    checkOutput("ram9_alt",     32'(ram[9]),  32'd2);
    checkOutput("ram10_inter",  32'(ram[10]), 32'd2);
    checkOutput("ram11_inter",  32'(ram[11]), 32'd0);

    // Clear with two updates in flight; the request offered with clear is refused.
    applyStimulus(5'd3, 1'b1, satNext(model[3], 1'b1));
    applyStimulus(5'd4, 1'b0, satNext(model[4], 1'b0));
    upd_valid_i = 1'b1;
    upd_idx_i   = 5'd6;
    upd_taken_i = 1'b1;
    clear_i     = 1'b1;
    #1;
    checkOutput("clear_ready", 32'(upd_ready_o), 32'd0);
    pushSweep();
    @(posedge clk);
    #1;
    clear_i     = 1'b0;
    upd_valid_i = 1'b0;
    k = 0;
    while (init_busy_o && k < 60) begin
      checkOutput("clear_ready_low", 32'(upd_ready_o), 32'd0);
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("clear_busy_low", 32'(init_busy_o), 32'd0);
    checkOutput("clear_sb_empty", 32'(sb.size()),   32'd0);
    for (int i = 0; i < N; i++) checkOutput($sformatf("clear_ram%0d", i), 32'(ram[i]), 32'd1);

    // Reset mid-sweep at entry 17.
    resetDut();
    k = 0;
    while (ram_wa_o != 5'd17 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("reach_entry17", 32'(ram_wa_o), 32'd17);
    resetDut();
    waitSweep("restart17");

    // Reset with S2 valid: the pending write must vanish.
    applyStimulus(5'd5, 1'b1, satNext(model[5], 1'b1));
    upd_valid_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("s2_we", 32'(ram_we_o), 32'd1);
    checkOutput("s2_wa", 32'(ram_wa_o), 32'd5);
    resetDut();
    waitSweep("restart_s2");
    checkOutput("ram5_no_stale", 32'(ram[5]), 32'd1);

    checkOutput("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
